// File: rtl/seq_mult_adder_ctrl.sv
// Shift-add multiplier sequencing one external 2*WIDTH adder; SIGNED_MULT_EN adds sign-magnitude handling via a NEG cycle.
// Latency: done in the (WIDTH+1)th cycle after the start edge, +1 cycle for a negative signed result.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE.
module seq_mult_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   adderA,
    output logic [2*WIDTH-1:0]   adderB,
    output logic                 adderCin,
    input  logic [2*WIDTH-1:0]   adderResult,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIGNED_MULT_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] mag_a, mag_b;

`ifdef SIGNED_MULT_EN
    logic neg_q, neg_d;
    // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
    assign mag_a = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;
    assign mag_b = multiplier[WIDTH-1]   ? (~multiplier + WIDTH'(1))   : multiplier;
`else
    assign mag_a = multiplicand;
    assign mag_b = multiplier;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
`ifdef SIGNED_MULT_EN
        neg_d     = neg_q;
`endif
        adderA    = acc_q;
        adderB    = mplier_q[0] ? mcand_q : '0;
        adderCin  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    mcand_d   = {{WIDTH{1'b0}}, mag_a};
                    mplier_d  = mag_b;
                    count_d   = '0;
                    product_d = '0;
`ifdef SIGNED_MULT_EN
                    neg_d     = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`endif
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = adderResult;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
`ifdef SIGNED_MULT_EN
                    if (neg_q) begin
                        state_d = S_NEG;
                    end else begin
                        product_d = adderResult;
                        state_d   = S_DONE;
                    end
`else
                    product_d = adderResult;
                    state_d   = S_DONE;
`endif
                end
            end
`ifdef SIGNED_MULT_EN
            S_NEG: begin
                // Two's complement negate of the magnitude through the shared adder: ~acc + 1.
                adderA    = ~acc_q;
                adderB    = '0;
                adderCin  = 1'b1;
                acc_d     = adderResult;
                product_d = adderResult;
                state_d   = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
`ifdef SIGNED_MULT_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
`ifdef SIGNED_MULT_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_adder_ctrl.sv
// Bench for seq_mult_adder_ctrl: behavioural external adder, scoreboard of expected products and latencies.
module tb_seq_mult_adder_ctrl;
    localparam int W  = 32;
    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic [PW-1:0] adderA, adderB, adderResult;
    logic          adderCin;
    logic          busy, done;
    logic [PW-1:0] product;

    int checks = 0;
    int failures = 0;

    logic [PW-1:0] exp_prod_q[$];
    int            exp_lat_q[$];

    seq_mult_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .adderA      (adderA),
        .adderB      (adderB),
        .adderCin    (adderCin),
        .adderResult (adderResult),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    // The shared carry-lookahead adder lives outside the block.
    assign adderResult = adderA + adderB + {{(PW-1){1'b0}}, adderCin};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic expect_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [PW-1:0] p, output int lat);
`ifdef SIGNED_MULT_EN
        logic signed [PW-1:0] sa, sb;
        sa  = {{W{a[W-1]}}, a};
        sb  = {{W{b[W-1]}}, b};
        p   = sa * sb;
        lat = (a[W-1] ^ b[W-1]) ? W + 2 : W + 1;
`else
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        lat = W + 1;
`endif
    endtask

    // cyc counts cycles after the accepted start edge; cycle 1 is the first RUN cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int abort_at, input int intrude_at, input bit trace);
        logic [PW-1:0] ep, got_p, mc;
        logic [W-1:0]  mp;
        int el, cyc, dones, done_cyc;
        expect_result(a, b, ep, el);
        exp_prod_q.push_back(ep);
        exp_lat_q.push_back(el);
`ifdef SIGNED_MULT_EN
        mc = {{W{1'b0}}, (a[W-1] ? (~a + 32'd1) : a)};
        mp = b[W-1] ? (~b + 32'd1) : b;
`else
        mc = {{W{1'b0}}, a};
        mp = b;
`endif
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        dones    = 0;
        done_cyc = 0;
        chk("prod_clr_on_start", product, '0);
        while (cyc <= 60) begin
            if (trace && cyc <= W) begin
                chk("busy_run", {63'd0, busy}, 64'd1);
                chk("adderB_gate", adderB, mp[0] ? mc : '0);
                mc = mc << 1;
                mp = mp >> 1;
            end
            if (cyc == intrude_at) begin
                multiplicand = 32'd2;
                multiplier   = 32'd2;
                start        = 1'b1;
            end
            if (cyc == intrude_at + 1) start = 1'b0;
            if (cyc == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", {63'd0, busy}, 64'd0);
                chk("abort_done", {63'd0, done}, 64'd0);
                chk("abort_product", product, '0);
                rst = 1'b0;
                void'(exp_prod_q.pop_back());
                void'(exp_lat_q.pop_back());
                return;
            end
`ifdef SIGNED_MULT_EN
            if (el == W + 2 && cyc == W + 1)
                chk("neg_cin", {63'd0, adderCin}, 64'd1);
`endif
            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_cyc = cyc;
                    got_p = exp_prod_q.pop_front();
                    chk("latency", 64'(cyc), 64'(exp_lat_q.pop_front()));
                    chk("product", product, got_p);
                    chk("done_cin", {63'd0, adderCin}, 64'd0);
                end
            end
            if (done_cyc != 0 && cyc == done_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        chk("done_pulses", 64'(dones), 64'd1);
        chk("idle_after", {63'd0, busy}, 64'd0);
        chk("product_hold", product, ep);
    endtask

    initial begin
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_product", product, '0);
        chk("rst_cin", {63'd0, adderCin}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        do_op(32'd3, 32'd5, -1, -1, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b1);
        do_op(32'd0, 32'h1234_5678, -1, -1, 1'b0);
        do_op(32'd7, 32'd9, -1, 10, 1'b0);
        do_op(32'd6, 32'd7, 12, -1, 1'b0);
        do_op(32'd6, 32'd7, -1, -1, 1'b0);
        do_op(32'hFFFF_FFFD, 32'd5, -1, -1, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
        for (int i = 0; i < 4; i++)
            do_op(W'($urandom), W'($urandom), -1, -1, 1'b0);

        chk("sb_empty", 64'(exp_prod_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
